// File: rtl/conditional_demux_stream.sv
// Registered 1-to-2 stream demux: routes one valid/ready stream to out1,
// out2 or both, with a one-entry slot and a wrapping transfer count per output.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid/ready/data   input stream
//   in_select             1 -> out1, 0 -> out2
//   in_bcast              1 -> both outputs (atomic)
//   outN_valid/ready/data output streams (N = 1, 2)
//   outN_count            completed outN handshakes, wrapping
//   busy                  either slot holds an item
module conditional_demux_stream #(
   parameter int size      = 1,
   parameter int cnt_width = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [size-1:0]      in_data,
   input  logic                 in_select,
   input  logic                 in_bcast,
   output logic                 out1_valid,
   input  logic                 out1_ready,
   output logic [size-1:0]      out1_data,
   output logic                 out2_valid,
   input  logic                 out2_ready,
   output logic [size-1:0]      out2_data,
   output logic [cnt_width-1:0] out1_count,
   output logic [cnt_width-1:0] out2_count,
   output logic                 busy
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_state_t;

   slot_state_t          r_st1;
   slot_state_t          r_st2;
   logic [size-1:0]      r_data1;
   logic [size-1:0]      r_data2;
   logic [cnt_width-1:0] r_cnt1;
   logic [cnt_width-1:0] r_cnt2;

   logic w_free1;
   logic w_free2;
   logic w_accept;
   logic w_load1;
   logic w_load2;
   logic w_drain1;
   logic w_drain2;

   assign out1_valid = (r_st1 == S_FULL);
   assign out2_valid = (r_st2 == S_FULL);
   assign out1_data  = r_data1;
   assign out2_data  = r_data2;
   assign out1_count = r_cnt1;
   assign out2_count = r_cnt2;
   assign busy       = out1_valid | out2_valid;

   // A slot can take a new item if empty or draining this cycle.
   assign w_free1  = !out1_valid | out1_ready;
   assign w_free2  = !out2_valid | out2_ready;
   assign w_drain1 = out1_valid & out1_ready;
   assign w_drain2 = out2_valid & out2_ready;

   // Only the targeted slot(s) gate the input; broadcast needs both.
   always_comb begin
      in_ready = 1'b0;
      if (in_bcast)
         in_ready = w_free1 & w_free2;
      else if (in_select)
         in_ready = w_free1;
      else
         in_ready = w_free2;
   end

   assign w_accept = in_valid & in_ready;
   assign w_load1  = w_accept & (in_bcast | in_select);
   assign w_load2  = w_accept & (in_bcast | !in_select);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_st1   <= S_EMPTY;
         r_data1 <= '0;
         r_cnt1  <= '0;
      end else begin
         if (w_drain1)
            r_cnt1 <= r_cnt1 + 1'b1;
         unique case (r_st1)
            S_EMPTY: begin
               if (w_load1) begin
                  r_st1   <= S_FULL;
                  r_data1 <= in_data;
               end
            end
            S_FULL: begin
               if (w_load1)
                  r_data1 <= in_data;
               else if (w_drain1)
                  r_st1 <= S_EMPTY;
            end
            default: r_st1 <= S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_st2   <= S_EMPTY;
         r_data2 <= '0;
         r_cnt2  <= '0;
      end else begin
         if (w_drain2)
            r_cnt2 <= r_cnt2 + 1'b1;
         unique case (r_st2)
            S_EMPTY: begin
               if (w_load2) begin
                  r_st2   <= S_FULL;
                  r_data2 <= in_data;
               end
            end
            S_FULL: begin
               if (w_load2)
                  r_data2 <= in_data;
               else if (w_drain2)
                  r_st2 <= S_EMPTY;
            end
            default: r_st2 <= S_EMPTY;
         endcase
      end
   end

   // Unknown steering on a possible accept leaves slot contents undefined.
   always @(posedge clk) begin
      if (!reset && in_valid && (in_ready !== 1'b0))
         assert (!$isunknown({in_select, in_bcast}))
         else $error("conditional_demux_stream: X/Z steering on accept");
   end

endmodule
